// File: rtl/prog_loader_pkg.sv
// Shared constants, state encoding and address helper for the program loader.
package prog_loader_pkg;

    localparam int unsigned LEN_W      = 16;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = 8 * WORD_BYTES;
    localparam int unsigned ADDR_W     = 32;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Loader states; kept as plain constants so older netlists can match encodings
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEN_HI = 3'd1;
    localparam state_t ST_LEN_LO = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_CHK    = 3'd4;
    localparam state_t ST_DONE   = 3'd5;
    localparam state_t ST_ERR    = 3'd6;

    // Byte address of word idx relative to base
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LEN_W-1:0]  idx);
        return base + (ADDR_W'(idx) << 2);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream and instruction-memory write port of the program loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic                in_valid;
    logic [7:0]          in_data;
    logic                in_ready;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WORD_W-1:0]   wr_data;

    // Master: host plus memory side; slave: the loader itself
    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/prog_loader_word_packer.sv
// Packs bytes MSB-first into 32-bit words; word_valid pulses for one cycle after each 4th byte.
module prog_loader_word_packer
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic              last_c,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        byte_cnt;
    logic [WORD_W-9:0] shift_q;

    // High when the next shifted byte completes a word
    assign last_c = (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (clear) begin
            byte_cnt   <= 2'd0;
            shift_q    <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= shift_en && last_c;
            if (shift_en) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift_q  <= {shift_q[WORD_W-17:0], byte_in};
                if (last_c) begin
                    word <= {shift_q, byte_in};
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: writes instruction words and holds the CPU until a load completes.
// Build option PROG_LOADER_CHECKSUM_EN adds and verifies the trailing XOR checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned       MAX_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned       TIMEOUT   = 100000
) (
    input  logic             clk,
    input  logic             reset,
    prog_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] word_count
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, count_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [ADDR_W-1:0] addr_d;
    logic              done_d, error_d, hold_d;
    logic              xfer_c, in_frame_c, frame_start_c;
    logic              pk_clear_c, pk_shift_c, pk_last_c;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    assign xfer_c     = bus.in_valid && bus.in_ready;
    assign in_frame_c = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                        (state_q == ST_DATA)   || (state_q == ST_CHK);
    // Reset and frame start both drop any partially assembled word
    assign pk_clear_c = !reset || frame_start_c;

    prog_loader_word_packer u_word_packer (
        .clk        (clk),
        .clear      (pk_clear_c),
        .shift_en   (pk_shift_c),
        .byte_in    (bus.in_data),
        .last_c     (pk_last_c),
        .word_valid (bus.wr_en),
        .word       (bus.wr_data)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        count_d       = word_count;
        addr_d        = bus.wr_addr;
        done_d        = done;
        error_d       = error;
        hold_d        = cpu_hold;
        frame_start_c = 1'b0;
        pk_shift_c    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d         = chk_q;
`endif
        idle_d        = (in_frame_c && !xfer_c) ? idle_q + IDLE_W'(1) : '0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (xfer_c && (bus.in_data == SYNC_BYTE)) begin
                    frame_start_c = 1'b1;
                    state_d       = ST_LEN_HI;
                    len_d         = '0;
                    count_d       = '0;
                    addr_d        = BASE_ADDR;
                    done_d        = 1'b0;
                    error_d       = 1'b0;
                    hold_d        = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d         = 8'h00;
`endif
                end
            end

            ST_LEN_HI: begin
                if (xfer_c) begin
                    len_d   = {bus.in_data, 8'h00};
                    state_d = ST_LEN_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ bus.in_data;
`endif
                end
            end

            ST_LEN_LO: begin
                if (xfer_c) begin
                    len_d = {len_q[LEN_W-1:8], bus.in_data};
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ bus.in_data;
`endif
                    if (len_d == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
`endif
                    end else if (len_d > LEN_W'(MAX_WORDS)) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                        hold_d  = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (xfer_c) begin
                    pk_shift_c = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d      = chk_q ^ bus.in_data;
`endif
                    // This byte completes a word: the packer raises wr_en next cycle
                    if (pk_last_c) begin
                        addr_d  = word_addr(BASE_ADDR, word_count);
                        count_d = word_count + LEN_W'(1);
                        if (count_d == len_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_d = ST_CHK;
`else
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            hold_d  = 1'b0;
`endif
                        end
                    end
                end
            end

`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (xfer_c) begin
                    if (bus.in_data == chk_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                        hold_d  = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stalled host aborts the frame
        if (in_frame_c && !xfer_c && (idle_q == IDLE_W'(TIMEOUT - 1))) begin
            state_d = ST_ERR;
            error_d = 1'b1;
            hold_d  = 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            idle_q       <= '0;
            word_count   <= '0;
            bus.wr_addr  <= BASE_ADDR;
            bus.in_ready <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idle_q       <= idle_d;
            word_count   <= count_d;
            bus.wr_addr  <= addr_d;
            bus.in_ready <= 1'b1;
            done         <= done_d;
            error        <= error_d;
            cpu_hold     <= hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory read path.
- Receives a framed byte stream from a host over a valid/ready handshake and packs the bytes into 32-bit instruction words.
- Writes each word into instruction memory at word-aligned byte addresses.
- Holds the processor in reset until a complete, checksum-verified program has been loaded.

Parameters:
- MAX_WORDS, 1024, largest accepted word count (4 KB instruction memory).
- BASE_ADDR, 32'h0000_0000, byte address of the first written word. Must be word-aligned.
- TIMEOUT, 100000, idle cycles allowed between bytes mid-frame before the frame is aborted.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  host byte valid
- in_data  input  8  host byte
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready on a rising clk edge
- wr_en  output  1  instruction-memory write strobe, one-cycle pulse
- wr_addr  output  32  byte address of the write, word-aligned
- wr_data  output  32  instruction word
- cpu_hold  output  1  processor reset request, high until a successful load
- done  output  1  load completed and verified (sticky)
- error  output  1  frame aborted (sticky until the next sync byte)
- word_count  output  16  words written in the current frame

Behaviour:
- Reset (reset==0 at a clk edge) sets all outputs: wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=1, done=0, error=0, word_count=0, in_ready=0. State goes to IDLE.
- Outside reset, in_ready=1 in every state.
- Frame format:
  - SYNC byte 0xA5
  - LEN_HI, LEN_LO: word count N, big-endian
  - N words, 4 bytes each, MSB first
  - CHK byte: XOR of LEN_HI, LEN_LO and all data bytes
- State machine:
  - IDLE: bytes other than 0xA5 are discarded. 0xA5 -> LEN_HI, clears done, error and word_count, sets cpu_hold=1, resets wr_addr to BASE_ADDR.
  - LEN_HI -> LEN_LO on the next byte.
  - LEN_LO: N==0 -> CHK. N>MAX_WORDS -> ERR. Otherwise -> DATA.
  - DATA: shift bytes into the packer. On the 4th byte, the next cycle asserts wr_en=1 with wr_data = the assembled word and wr_addr = BASE_ADDR + 4*word_count. word_count then increments. After the Nth word -> CHK.
  - CHK: byte equals the running XOR -> DONE, else -> ERR.
  - DONE: done=1 and cpu_hold=0 from the cycle after the CHK byte is accepted.
  - ERR: error=1 and cpu_hold=1.
  - From DONE or ERR, a 0xA5 byte restarts the frame as from IDLE; any other byte is discarded.
- Timeout: in LEN_HI, LEN_LO, DATA or CHK, TIMEOUT consecutive cycles without a transfer -> ERR. The idle counter clears on every transfer.
- Words written before an error remain in memory. The loader does not roll them back.
- wr_en never asserts outside DATA. At most one write per 4 accepted bytes.
- Reset mid-frame abandons the frame immediately. No further wr_en pulse issues, including for a partially assembled word.
- word_count saturates at N. wr_addr increments by 4 per write and never wraps within a legal frame.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined: CHK byte is required and compared as described above.
- Undefined: there is no CHK byte. After the Nth word is accepted, the state goes straight to DONE; done and cpu_hold update the cycle after the last byte, coincident with the final wr_en. With N==0, LEN_LO goes directly to DONE. Checksum logic is not generated.

Decomposition:
- Package prog_loader_pkg holds:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR)
  - SYNC_BYTE = 8'hA5
  - LEN_W = 16, WORD_BYTES = 4
- Sub-module word_packer: 8-to-32 shift register with a 2-bit byte counter. Emits word_valid for one cycle after the 4th byte; clear input is used on frame start and reset.

Test Plan:
- Load 0xA5, 0x00, 0x02, then bytes 20 08 00 05 01 09 50 20, then CHK 0x57 -> wr_en pulses at addr 0x0 with data 0x20080005 and at addr 0x4 with data 0x01095020. done=1 and cpu_hold=0 one cycle after CHK.
- Same frame with CHK 0x58 -> both writes occur, then error=1, done=0, cpu_hold=1. A following valid frame recovers to done=1.
- LEN = 0x0401 (1025 > MAX_WORDS) -> error=1 right after LEN_LO, with zero wr_en pulses.
- Bytes 0x00, 0x13 before 0xA5 are discarded, then a valid 1-word frame loads normally, with word_count=1.
- Stall TIMEOUT cycles after the 2nd data byte -> error=1 with no write. Assert reset mid-word in a second run -> outputs return to reset values with no write.
- With the macro undefined: 0xA5 00 01 DE AD BE EF -> one write of 0xDEADBEEF at 0x0, and done=1 in the same cycle as wr_en.
